// File: rtl/model_state_output_reader.sv
// model_state_output_reader: captures one y-vector from the model, then replays it in order over valid/ready.
module model_state_output_reader #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int Y            = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [CONTROL_SIZE-1:0] SIZE_Y_IN,
  input  logic                    Y_IN_VALID,
  input  logic [DATA_SIZE-1:0]    Y_IN,
  output logic                    Y_IN_ACK,
  output logic                    DATA_OUT_ENABLE,
  input  logic                    DATA_OUT_READY,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic [CONTROL_SIZE-1:0] INDEX_OUT,
  output logic                    READY,
  output logic                    ERROR
);
  localparam int AW = Y > 1 ? $clog2(Y) : 1;
  localparam logic [CONTROL_SIZE-1:0] ONE = CONTROL_SIZE'(1);
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;
  state_t state;
  logic [CONTROL_SIZE-1:0] n, wr, rd;
  logic [DATA_SIZE-1:0] mem [Y];
  logic err, bad;
  assign bad = SIZE_Y_IN == '0 || SIZE_Y_IN > CONTROL_SIZE'(Y);
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      n     <= '0;
      wr    <= '0;
      rd    <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (START) begin
          n  <= SIZE_Y_IN;
          wr <= '0;
          rd <= '0;
          if (bad) err <= 1'b1;
          else state <= CAPTURE;
        end
        CAPTURE: if (Y_IN_VALID) begin
          wr <= wr + ONE;
          if (wr == n - ONE) begin
            state <= DRAIN;
            rd    <= '0;
          end
        end
        DRAIN: if (DATA_OUT_READY) begin
          rd <= rd + ONE;
          if (rd == n - ONE) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // buffer is never reset; only indices below the latched length are ever read
  always_ff @(posedge CLK)
    if (state == CAPTURE && Y_IN_VALID) mem[wr[AW-1:0]] <= Y_IN;
  assign Y_IN_ACK        = state == CAPTURE;
  assign DATA_OUT_ENABLE = state == DRAIN;
  assign DATA_OUT        = state == DRAIN ? mem[rd[AW-1:0]] : '0;
  assign INDEX_OUT       = state == DRAIN ? rd : '0;
  assign READY           = state == DONE || err;
  assign ERROR           = err;
endmodule

// File: tb/tb_model_state_output_reader.sv
// tb_model_state_output_reader: randomized and directed checks against a queue-based reference model.
module tb_model_state_output_reader;
  logic        clk = 1'b0;
  logic        RST = 1'b1, START = 1'b0, Y_IN_VALID = 1'b0, DATA_OUT_READY = 1'b0;
  logic [63:0] SIZE_Y_IN = '0, Y_IN = '0;
  logic        Y_IN_ACK, DATA_OUT_ENABLE, READY, ERROR;
  logic [63:0] DATA_OUT, INDEX_OUT;

  model_state_output_reader dut (
    .CLK(clk), .RST(RST), .START(START), .SIZE_Y_IN(SIZE_Y_IN),
    .Y_IN_VALID(Y_IN_VALID), .Y_IN(Y_IN), .Y_IN_ACK(Y_IN_ACK),
    .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .DATA_OUT_READY(DATA_OUT_READY),
    .DATA_OUT(DATA_OUT), .INDEX_OUT(INDEX_OUT), .READY(READY), .ERROR(ERROR)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0;
  bit live = 0;

  function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endfunction

  // reference model: elements still owed by the producer, and the queue awaiting replay
  longint      rem = 0, idx = 0;
  logic [63:0] q[$];
  bit          donep = 0, errp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (RST) begin
      rem = 0; idx = 0; q.delete(); donep = 0; errp = 0; live = 1;
    end else if (live) begin
      errp = 0;
      if (donep) donep = 0;
      else if (rem > 0) begin
        if (Y_IN_VALID) begin q.push_back(Y_IN); rem--; end
      end else if (q.size() > 0) begin
        if (DATA_OUT_READY) begin
          void'(q.pop_front());
          idx++;
          if (q.size() == 0) donep = 1;
        end
      end else if (START) begin
        if (SIZE_Y_IN == 0 || SIZE_Y_IN > 64) errp = 1;
        else begin rem = longint'(SIZE_Y_IN); idx = 0; end
      end
    end
  end

  always @(negedge clk) if (live) begin
    bit en;
    en = rem == 0 && q.size() > 0;
    chk("ack", Y_IN_ACK, rem > 0);
    chk("enable", DATA_OUT_ENABLE, en);
    chk("data", DATA_OUT, en ? q[0] : 64'd0);
    chk("index", INDEX_OUT, en ? idx : 64'd0);
    chk("ready", READY, donep || errp);
    chk("error", ERROR, errp);
  end

  // observations of the handshakes, used by the directed literal checks
  int          ptr = 0, ready_cnt = 0, err_cnt = 0, ready_cyc = -1;
  logic [63:0] seen[$], seen_idx[$];
  int          seen_cyc[$];
  logic [63:0] src[65];

  always @(negedge clk) if (live && !RST) begin
    if (Y_IN_VALID && Y_IN_ACK) ptr++;
    if (DATA_OUT_ENABLE && DATA_OUT_READY) begin
      seen.push_back(DATA_OUT); seen_idx.push_back(INDEX_OUT); seen_cyc.push_back(cyc);
    end
    if (READY) begin ready_cnt++; ready_cyc = cyc; end
    if (ERROR) err_cnt++;
  end

  task automatic drive(input bit st, input logic [63:0] sz, input bit v, input bit r);
    @(posedge clk); #1;
    RST = 1'b0; START = st; SIZE_Y_IN = sz; Y_IN_VALID = v; DATA_OUT_READY = r;
    Y_IN = src[ptr % 65];
  endtask

  function automatic bit pat(int mode, int k, int period);
    return mode == 0 ? 1'b1 : mode == 1 ? (k % period == period - 1) : 1'($urandom_range(1));
  endfunction

  task automatic run(input logic [63:0] n, input int vm, input int rm, input bit noise,
                     input int budget, output int s);
    int r0, k;
    r0 = ready_cnt; k = 0; ptr = 0;
    seen.delete(); seen_idx.delete(); seen_cyc.delete();
    drive(1'b1, n, pat(vm, 0, 2), pat(rm, 0, 3));
    s = cyc;
    @(negedge clk); #1;
    while (ready_cnt == r0 && k < budget) begin
      k++;
      drive(noise && $urandom_range(3) == 0, {$urandom, $urandom}, pat(vm, k, 2), pat(rm, k, 3));
      @(negedge clk); #1;
    end
    if (ready_cnt == r0) begin
      errors++;
      $display("FAIL timeout: no READY within %0d cycles for n=%0d", budget, n);
    end
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    @(negedge clk); #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, r0, e0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ack", Y_IN_ACK, 0); chk("rst_en", DATA_OUT_ENABLE, 0); chk("rst_data", DATA_OUT, 0);
    chk("rst_idx", INDEX_OUT, 0); chk("rst_ready", READY, 0); chk("rst_error", ERROR, 0);

    // four elements, everything always ready
    for (int i = 0; i < 65; i++) src[i] = 64'd10 * (i + 1);
    run(4, 0, 0, 0, 50, s);
    chk("t1_count", seen.size(), 4);
    for (int i = 0; i < seen.size(); i++) begin
      chk("t1_data", seen[i], 64'd10 * (i + 1));
      chk("t1_idx", seen_idx[i], i);
      chk("t1_cyc", seen_cyc[i], s + 5 + i);
    end
    chk("t1_ready_cyc", ready_cyc, s + 9);
    chk("t1_transfers", ptr, 4);

    // toggling producer, consumer ready every third cycle
    src[0] = 7; src[1] = 8; src[2] = 9; src[3] = 99;
    run(3, 1, 1, 0, 100, s);
    chk("t2_transfers", ptr, 3);
    chk("t2_count", seen.size(), 3);
    for (int i = 0; i < seen.size(); i++) begin
      chk("t2_data", seen[i], 7 + i);
      chk("t2_idx", seen_idx[i], i);
    end

    // illegal sizes
    foreach (src[i]) src[i] = i;
    e0 = err_cnt;
    run(0, 0, 0, 0, 10, s);
    chk("t3_zero_ready_cyc", ready_cyc, s + 1);
    chk("t3_zero_transfers", ptr, 0);
    run(65, 0, 0, 0, 10, s);
    chk("t3_big_ready_cyc", ready_cyc, s + 1);
    chk("t3_big_transfers", ptr, 0);
    chk("t3_err_pulses", err_cnt - e0, 2);

    // full depth with producer held valid
    run(64, 0, 2, 0, 1000, s);
    chk("t4_transfers", ptr, 64);
    chk("t4_count", seen.size(), 64);
    for (int i = 0; i < seen.size(); i++) chk("t4_data", seen[i], i);

    // reset during replay at index 2 of 5
    r0 = ready_cnt; ptr = 0;
    drive(1'b1, 5, 1'b1, 1'b1);
    repeat (7) drive(1'b0, 0, 1'b1, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b1);
    RST = 1'b1;
    @(negedge clk); #1;
    chk("t5_idx_before_rst", INDEX_OUT, 2);
    drive(1'b0, 0, 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("t5_en", DATA_OUT_ENABLE, 0); chk("t5_data", DATA_OUT, 0); chk("t5_idx", INDEX_OUT, 0);
    chk("t5_ack", Y_IN_ACK, 0); chk("t5_ready", READY, 0);
    repeat (4) drive(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("t5_no_ready", ready_cnt - r0, 0);
    src[0] = 64'hAA; src[1] = 64'hBB;
    run(2, 0, 0, 0, 20, s);
    chk("t5_after_count", seen.size(), 2);
    if (seen.size() == 2) begin chk("t5_after_d0", seen[0], 64'hAA); chk("t5_after_d1", seen[1], 64'hBB); end

    // START held high across DONE: one op every 6 cycles for n=2
    r0 = ready_cnt;
    repeat (20) drive(1'b1, 2, 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("t6_ready_20", ready_cnt - r0, 3);
    repeat (10) drive(1'b0, 0, 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("t6_ready_total", ready_cnt - r0, 4);

    // randomized operations with stray START pulses during operation
    for (int t = 0; t < 40; t++) begin
      logic [63:0] n;
      foreach (src[i]) src[i] = {$urandom, $urandom};
      n = $urandom_range(9) == 0 ? ($urandom_range(1) ? 64'd0 : 64'd65 + $urandom_range(100)) : 64'($urandom_range(1, 12));
      run(n, 2, 2, n != 0 && n <= 64, 600, s);
      if (n != 0 && n <= 64) chk("rand_transfers", ptr, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
